// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the parametrised register file
//               and its pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // Hard-wired zero register index
  localparam int ZERO_REG = 0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register pending-write flags. A claim marks a register as
//               awaiting a multi-cycle result; the matching write clears it.
//               Also produces the per-port busy view with optional bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic                          claim_en,
  input  logic [ADDR_W-1:0]             claim_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]             rd_busy
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam bit                BYP    = (BYPASS != 0);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic w_wr_ok;
  logic w_claim_ok;
  logic w_same;

  assign w_wr_ok    = wr_en && (wr_addr != ZERO_A);
  assign w_claim_ok = claim_en && (claim_addr != ZERO_A);
  // A claim to the register being written belongs to a newer instruction
  assign w_same     = w_claim_ok && (claim_addr == wr_addr);

  // Next busy state: write clears, claim sets afterwards so it wins
  always_comb begin
    busy_d = busy_q;
    if (w_wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (w_claim_ok) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy flag register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port busy: a same-cycle write (no competing claim) frees it early
  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_busy
      logic w_free_now;
      assign w_free_now = BYP && w_wr_ok && !w_same && (wr_addr == rd_addr[p]);
      assign rd_busy[p] = busy_q[rd_addr[p]] && !w_free_now;
    end
  endgenerate

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_scb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scb
// Description : Parametrised CPU register file with combinational read ports,
//               optional write-to-read bypass, pending-write scoreboard,
//               hard-wired zero register and an exported output register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int BYPASS  = 1,
  parameter int OUT_IDX = 2 ** ADDR_W - 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          claim_en,
  input  logic [ADDR_W-1:0]             claim_addr,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_strobe
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] OUT_A  = ADDR_W'(OUT_IDX);
  localparam bit                BYP    = (BYPASS != 0);

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic              out_strobe_q;
  logic              w_wr_ok;

  // Gating with rst_n keeps the bypass path quiet while held in reset
  assign w_wr_ok = rst_n && wr_en && (wr_addr != ZERO_A);

  // Register storage and output-port strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
      out_strobe_q <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        rf_q[wr_addr] <= wr_data;
      end
      out_strobe_q <= w_wr_ok && (wr_addr == OUT_A);
    end
  end

  // Combinational read ports with optional same-cycle bypass
  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
      logic w_hit;
      assign w_hit      = BYP && w_wr_ok && (wr_addr == rd_addr[p]);
      assign rd_data[p] = w_hit ? wr_data : rf_q[rd_addr[p]];
    end
  endgenerate

  assign out_data   = rf_q[OUT_A];
  assign out_strobe = out_strobe_q;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy)
  );

endmodule : regfile_scb
`default_nettype wire

// File: tb/tb_regfile_scb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scb
// Description : Scoreboard bench for regfile_scb. Three instances: default
//               with bypass (A), default without bypass (B) and a wide
//               16-bit / 32-entry / 3-port configuration (C).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Shared stimulus for A and B
  logic [1:0][3:0] ab_rd_addr;
  logic            ab_wr_en;
  logic [3:0]      ab_wr_addr;
  logic [7:0]      ab_wr_data;
  logic            ab_claim_en;
  logic [3:0]      ab_claim_addr;

  logic [1:0][7:0] a_rd_data, b_rd_data;
  logic [1:0]      a_rd_busy, b_rd_busy;
  logic [7:0]      a_out_data, b_out_data;
  logic            a_out_strobe, b_out_strobe;

  // Stimulus for wide instance C
  logic [2:0][4:0]  c_rd_addr;
  logic             c_wr_en;
  logic [4:0]       c_wr_addr;
  logic [15:0]      c_wr_data;
  logic             c_claim_en;
  logic [4:0]       c_claim_addr;
  logic [2:0][15:0] c_rd_data;
  logic [2:0]       c_rd_busy;
  logic [15:0]      c_out_data;
  logic             c_out_strobe;

  regfile_scb #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2), .BYPASS(1), .OUT_IDX(15)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(ab_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(ab_wr_en), .wr_addr(ab_wr_addr), .wr_data(ab_wr_data),
    .claim_en(ab_claim_en), .claim_addr(ab_claim_addr),
    .out_data(a_out_data), .out_strobe(a_out_strobe)
  );

  regfile_scb #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2), .BYPASS(0), .OUT_IDX(15)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(ab_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(ab_wr_en), .wr_addr(ab_wr_addr), .wr_data(ab_wr_data),
    .claim_en(ab_claim_en), .claim_addr(ab_claim_addr),
    .out_data(b_out_data), .out_strobe(b_out_strobe)
  );

  regfile_scb #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .BYPASS(1), .OUT_IDX(31)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .claim_en(c_claim_en), .claim_addr(c_claim_addr),
    .out_data(c_out_data), .out_strobe(c_out_strobe)
  );

  // Expected-value queue: one entry per observation, tagged with its cycle
  typedef struct {
    int           cyc;
    int           sig;
    logic [1:0]   port;
    logic [15:0]  exp;
    logic [127:0] name;
  } item_t;

  item_t       q[$];
  logic [15:0] sq[$];   // expected out_data for each out_strobe pulse

  int cyc     = 0;
  int errors  = 0;
  int checks  = 0;
  int strobes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Signal selector codes
  localparam int S_A_RD = 0, S_A_BUSY = 1, S_A_OUT = 2, S_A_STB = 3;
  localparam int S_B_RD = 4, S_B_BUSY = 5, S_C_RD = 6, S_C_OUT = 7;

  function automatic logic [15:0] actual(int sig, logic [1:0] port);
    case (sig)
      S_A_RD:   return {8'h00, a_rd_data[port[0]]};
      S_A_BUSY: return {15'h0, a_rd_busy[port[0]]};
      S_A_OUT:  return {8'h00, a_out_data};
      S_A_STB:  return {15'h0, a_out_strobe};
      S_B_RD:   return {8'h00, b_rd_data[port[0]]};
      S_B_BUSY: return {15'h0, b_rd_busy[port[0]]};
      S_C_RD:   return c_rd_data[port];
      S_C_OUT:  return c_out_data;
      default:  return 16'hDEAD;
    endcase
  endfunction

  task automatic ex(int sig, int port, logic [15:0] v, logic [127:0] nm);
    q.push_back('{cyc, sig, 2'(port), v, nm});
  endtask

  // Monitor: compare expectations for this cycle, and every strobe pulse
  always @(negedge clk) begin
    item_t       it;
    logic [15:0] act;
    logic [15:0] e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it  = q.pop_front();
      act = actual(it.sig, it.port);
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %0s (cycle %0d): got %h, expected %h", it.name, it.cyc, act, it.exp);
      end
    end
    if (a_out_strobe === 1'b1) begin
      strobes++;
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe (cycle %0d): got out_data %h, expected no strobe", cyc, a_out_data);
      end else begin
        e = sq.pop_front();
        if ({8'h00, a_out_data} !== e) begin
          errors++;
          $display("FAIL strobe_data (cycle %0d): got %h, expected %h", cyc, a_out_data, e);
        end
      end
    end
  end

  // Advance to just after the next rising edge with write/claim idle
  task automatic step();
    @(posedge clk);
    #1;
    ab_wr_en    = 1'b0;
    ab_claim_en = 1'b0;
    c_wr_en     = 1'b0;
    c_claim_en  = 1'b0;
  endtask

  task automatic ab_wr(logic [3:0] a, logic [7:0] d);
    ab_wr_en = 1'b1; ab_wr_addr = a; ab_wr_data = d;
  endtask

  task automatic ab_claim(logic [3:0] a);
    ab_claim_en = 1'b1; ab_claim_addr = a;
  endtask

  task automatic ab_rd(logic [3:0] a0, logic [3:0] a1);
    ab_rd_addr[0] = a0; ab_rd_addr[1] = a1;
  endtask

  initial begin
    rst_n = 1'b0;
    ab_rd_addr = '0; ab_wr_en = 1'b0; ab_wr_addr = '0; ab_wr_data = '0;
    ab_claim_en = 1'b0; ab_claim_addr = '0;
    c_rd_addr = '0; c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0;
    c_claim_en = 1'b0; c_claim_addr = '0;
    repeat (2) @(posedge clk);

    step(); rst_n = 1'b1;
    // Populate some state, then assert reset mid-write
    step(); ab_wr(4'd3, 8'h11); ab_rd(4'd3, 4'd3);
    ex(S_A_RD, 0, 16'h11, "pre_byp_r3"); ex(S_B_RD, 0, 16'h00, "pre_nobyp_r3");
    step(); ab_wr(4'd15, 8'h77); ab_claim(4'd5); ab_rd(4'd3, 4'd5);
    c_wr_en = 1'b1; c_wr_addr = 5'd31; c_wr_data = 16'h1234;
    ex(S_A_RD, 0, 16'h11, "pre_r3"); ex(S_B_RD, 0, 16'h11, "pre_b_r3");
    step(); ab_wr(4'd3, 8'h99); ab_claim(4'd5);
    c_wr_en = 1'b1; c_wr_addr = 5'd31; c_wr_data = 16'h5555;
    for (int i = 0; i < 3; i++) c_rd_addr[i] = 5'd31;
    #2 rst_n = 1'b0;
    ex(S_A_RD, 0, 16'h00, "rst_rd_p0"); ex(S_A_BUSY, 1, 16'h0, "rst_busy_p1");
    ex(S_A_OUT, 0, 16'h00, "rst_out"); ex(S_A_STB, 0, 16'h0, "rst_strobe");
    ex(S_B_RD, 0, 16'h00, "rst_b_rd"); ex(S_C_RD, 2, 16'h0000, "rst_c_rd");
    ex(S_C_OUT, 0, 16'h0000, "rst_c_out");
    step(); rst_n = 1'b1;
    ex(S_A_RD, 0, 16'h00, "rel_rd"); ex(S_A_BUSY, 1, 16'h0, "rel_busy");
    ex(S_A_OUT, 0, 16'h00, "rel_out"); ex(S_A_STB, 0, 16'h0, "rel_strobe");
    ex(S_C_OUT, 0, 16'h0000, "rel_c_out");

    // Basic write / read, bypass versus no bypass
    step(); ab_wr(4'd3, 8'hA5); ab_rd(4'd3, 4'd3);
    ex(S_A_RD, 0, 16'hA5, "byp_r3_p0"); ex(S_A_RD, 1, 16'hA5, "byp_r3_p1");
    ex(S_B_RD, 0, 16'h00, "nobyp_r3");
    step();
    ex(S_A_RD, 0, 16'hA5, "r3_p0"); ex(S_A_RD, 1, 16'hA5, "r3_p1");
    ex(S_B_RD, 1, 16'hA5, "b_r3_p1");

    // Register 0 ignores writes and claims
    step(); ab_wr(4'd0, 8'hFF); ab_claim(4'd0); ab_rd(4'd0, 4'd0);
    ex(S_A_RD, 0, 16'h00, "r0_byp"); ex(S_A_BUSY, 0, 16'h0, "r0_busy_now");
    ex(S_B_RD, 0, 16'h00, "b_r0");
    step();
    ex(S_A_RD, 1, 16'h00, "r0_rd"); ex(S_A_BUSY, 1, 16'h0, "r0_busy");

    // Scoreboard: claim, hold, write clears
    step(); ab_claim(4'd5); ab_rd(4'd5, 4'd5);
    ex(S_A_BUSY, 0, 16'h0, "r5_busy_pre");
    step();
    ex(S_A_BUSY, 0, 16'h1, "r5_busy_p0"); ex(S_A_BUSY, 1, 16'h1, "r5_busy_p1");
    ex(S_B_BUSY, 0, 16'h1, "b_r5_busy");
    step();
    ex(S_A_BUSY, 0, 16'h1, "r5_busy_hold");
    step(); ab_wr(4'd5, 8'h3C);
    ex(S_A_BUSY, 0, 16'h0, "r5_busy_byp"); ex(S_A_RD, 0, 16'h3C, "r5_byp");
    ex(S_B_BUSY, 0, 16'h1, "b_r5_busy_wr");
    step();
    ex(S_A_BUSY, 0, 16'h0, "r5_free"); ex(S_A_RD, 1, 16'h3C, "r5_rd");
    ex(S_B_BUSY, 0, 16'h0, "b_r5_free"); ex(S_B_RD, 0, 16'h3C, "b_r5_rd");

    // Claim and write to the same register in one cycle: claim wins
    step(); ab_claim(4'd5);
    ex(S_A_BUSY, 0, 16'h0, "r5_claim_pre");
    step(); ab_claim(4'd5); ab_wr(4'd5, 8'h5A);
    ex(S_A_BUSY, 0, 16'h1, "r5_cw_busy"); ex(S_A_RD, 0, 16'h5A, "r5_cw_byp");
    step();
    ex(S_A_BUSY, 0, 16'h1, "r5_cw_hold"); ex(S_A_RD, 1, 16'h5A, "r5_cw_rd");
    ex(S_B_BUSY, 1, 16'h1, "b_r5_cw");

    // Output register: back-to-back writes; wide instance write to r31
    step(); ab_wr(4'd15, 8'h42); sq.push_back(16'h42);
    c_wr_en = 1'b1; c_wr_addr = 5'd31; c_wr_data = 16'hBEEF;
    ex(S_A_OUT, 0, 16'h00, "out_pre"); ex(S_A_STB, 0, 16'h0, "strobe_pre");
    for (int i = 0; i < 3; i++) ex(S_C_RD, i, 16'hBEEF, "c_byp");
    ex(S_C_OUT, 0, 16'h0000, "c_out_pre");
    step(); ab_wr(4'd15, 8'h43); sq.push_back(16'h43);
    ex(S_A_STB, 0, 16'h1, "strobe_1"); ex(S_A_OUT, 0, 16'h42, "out_1");
    for (int i = 0; i < 3; i++) ex(S_C_RD, i, 16'hBEEF, "c_rd");
    ex(S_C_OUT, 0, 16'hBEEF, "c_out");
    step();
    ex(S_A_STB, 0, 16'h1, "strobe_2"); ex(S_A_OUT, 0, 16'h43, "out_2");
    step();
    ex(S_A_STB, 0, 16'h0, "strobe_end"); ex(S_A_OUT, 0, 16'h43, "out_hold");

    step(); step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expect: got %0d unchecked entries, expected 0", q.size());
    end
    checks++;
    if (strobes != 2 || sq.size() != 0) begin
      errors++;
      $display("FAIL strobe_count: got %0d strobes, expected 2", strobes);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_scb
`default_nettype wire
